// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for a ROWS x COLS systolic array: captures one A/B tile
// and streams it with lane i delayed by i steps. Optional valid masks: SKEW_VALID_MASK_EN.
module systolic_skew_feeder #(
   parameter int BW    = 8,
   parameter int ROWS  = 5,
   parameter int COLS  = 5,
   parameter int DEPTH = 5
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               iStart,
   input  logic                               iStall,
   input  logic [ROWS-1:0][DEPTH-1:0][BW-1:0] iRow,
   input  logic [COLS-1:0][DEPTH-1:0][BW-1:0] iCol,
   output logic [ROWS-1:0][BW-1:0]            oRow,
   output logic [COLS-1:0][BW-1:0]            oCol,
`ifdef SKEW_VALID_MASK_EN
   output logic [ROWS-1:0]                    oRowValid,
   output logic [COLS-1:0]                    oColValid,
`endif
   output logic                               oBusy,
   output logic                               oFinishedRearranging
);

   localparam int LANES = (ROWS > COLS) ? ROWS : COLS;
   localparam int T     = DEPTH + LANES - 1;
   localparam int SW    = $clog2(T + 1);
   localparam logic [SW-1:0] LAST = SW'(T - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
   typedef enum logic [1:0] {OUT_HOLD, OUT_ZERO, OUT_LOAD} out_mode_t;

   state_t                             state_q, state_d;
   logic [SW-1:0]                      step_q, step_d;
   logic [ROWS-1:0][DEPTH-1:0][BW-1:0] a_q, a_d;
   logic [COLS-1:0][DEPTH-1:0][BW-1:0] b_q, b_d;
   logic [ROWS-1:0][BW-1:0]            row_q, row_d, row_val;
   logic [COLS-1:0][BW-1:0]            col_q, col_d, col_val;
   out_mode_t                          out_mode;
`ifdef SKEW_VALID_MASK_EN
   logic [ROWS-1:0]                    rvld_q, rvld_d, row_hit;
   logic [COLS-1:0]                    cvld_q, cvld_d, col_hit;
`endif

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      a_d      = a_q;
      b_d      = b_q;
      out_mode = OUT_HOLD;
      unique case (state_q)
         IDLE, DONE: begin
            if (iStart) begin
               a_d      = iRow;
               b_d      = iCol;
               step_d   = '0;
               state_d  = STREAM;
               out_mode = OUT_LOAD;
            end else begin
               state_d  = IDLE;
               out_mode = OUT_ZERO;
            end
         end
         STREAM: begin
            if (!iStall) begin
               if (step_q == LAST) begin
                  state_d  = DONE;
                  out_mode = OUT_ZERO;
               end else begin
                  step_d   = step_q + 1'b1;
                  out_mode = OUT_LOAD;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            out_mode = OUT_ZERO;
         end
      endcase
   end

   // Lane values are taken from the next-state buffer/step so a capture edge
   // already presents step 0 from the freshly sampled tile.
   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         logic [BW-1:0] val;
         logic          hit;
         always_comb begin
            val = '0;
            hit = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
               if (int'(step_d) == gi + j) begin
                  val = a_d[gi][j];
                  hit = 1'b1;
               end
            end
         end
         assign row_val[gi] = val;
`ifdef SKEW_VALID_MASK_EN
         assign row_hit[gi] = hit;
`endif
      end
      for (gi = 0; gi < COLS; gi++) begin : g_col
         logic [BW-1:0] val;
         logic          hit;
         always_comb begin
            val = '0;
            hit = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
               if (int'(step_d) == gi + j) begin
                  val = b_d[gi][j];
                  hit = 1'b1;
               end
            end
         end
         assign col_val[gi] = val;
`ifdef SKEW_VALID_MASK_EN
         assign col_hit[gi] = hit;
`endif
      end
   endgenerate

   always_comb begin
      row_d = row_q;
      col_d = col_q;
`ifdef SKEW_VALID_MASK_EN
      rvld_d = rvld_q;
      cvld_d = cvld_q;
`endif
      case (out_mode)
         OUT_ZERO: begin
            row_d = '0;
            col_d = '0;
`ifdef SKEW_VALID_MASK_EN
            rvld_d = '0;
            cvld_d = '0;
`endif
         end
         OUT_LOAD: begin
            row_d = row_val;
            col_d = col_val;
`ifdef SKEW_VALID_MASK_EN
            rvld_d = row_hit;
            cvld_d = col_hit;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
`ifdef SKEW_VALID_MASK_EN
         rvld_q  <= '0;
         cvld_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         row_q   <= row_d;
         col_q   <= col_d;
`ifdef SKEW_VALID_MASK_EN
         rvld_q  <= rvld_d;
         cvld_q  <= cvld_d;
`endif
      end
   end

   assign oRow                 = row_q;
   assign oCol                 = col_q;
   assign oBusy                = (state_q == STREAM);
   assign oFinishedRearranging = (state_q == DONE);
`ifdef SKEW_VALID_MASK_EN
   assign oRowValid            = rvld_q;
   assign oColValid            = cvld_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: default 5x5x5 instance plus a 2x4x3 instance.
module tb_systolic_skew_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, iStart, iStall, iStart2;
   logic [4:0][4:0][7:0] iRow, iCol;
   logic [4:0][7:0]      oRow, oCol;
   logic                 oBusy, oFin;
   logic [1:0][2:0][7:0] iRow2;
   logic [3:0][2:0][7:0] iCol2;
   logic [1:0][7:0]      oRow2;
   logic [3:0][7:0]      oCol2;
   logic                 oBusy2, oFin2;
`ifdef SKEW_VALID_MASK_EN
   logic [4:0] oRowValid, oColValid;
   logic [1:0] oRowValid2;
   logic [3:0] oColValid2;
`endif

   int checks = 0;
   int errors = 0;

   systolic_skew_feeder #(.BW(8), .ROWS(5), .COLS(5), .DEPTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .iStart(iStart), .iStall(iStall),
      .iRow(iRow), .iCol(iCol), .oRow(oRow), .oCol(oCol),
`ifdef SKEW_VALID_MASK_EN
      .oRowValid(oRowValid), .oColValid(oColValid),
`endif
      .oBusy(oBusy), .oFinishedRearranging(oFin));

   systolic_skew_feeder #(.BW(8), .ROWS(2), .COLS(4), .DEPTH(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .iStart(iStart2), .iStall(1'b0),
      .iRow(iRow2), .iCol(iCol2), .oRow(oRow2), .oCol(oCol2),
`ifdef SKEW_VALID_MASK_EN
      .oRowValid(oRowValid2), .oColValid(oColValid2),
`endif
      .oBusy(oBusy2), .oFinishedRearranging(oFin2));

   // Expected element on a lane: base + stride*lane + k where k = s - lane
   function automatic logic [7:0] exp_lane(int base, int stride, int depth, int lane, int s);
      int k;
      k = s - lane;
      if (k >= 0 && k < depth) return 8'(base + stride * lane + k);
      return 8'd0;
   endfunction

   function automatic logic [39:0] exp_vec5(int base, int s);
      logic [4:0][7:0] v;
      for (int l = 0; l < 5; l++) v[l] = exp_lane(base, 5, 5, l, s);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_default(int col_base);
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            iRow[i][j] = 8'(5 * i + j);
            iCol[i][j] = 8'(5 * i + j + col_base);
         end
   endtask

   task automatic start_tile();
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iStart = 1'b0; iStall = 1'b0; iStart2 = 1'b0;
      iRow = '0; iCol = '0; iRow2 = '0; iCol2 = '0;
      #2;
      checks++;
      if (oRow !== '0 || oCol !== '0 || oBusy !== 1'b0 || oFin !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: oRow=%h oCol=%h busy=%b fin=%b, want all 0", oRow, oCol, oBusy, oFin);
      end
      tick(); tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      checks++;
      if (oRow !== '0 || oCol !== '0 || oBusy !== 1'b0 || oFin !== 1'b0) begin
         errors++;
         $display("FAIL idle_state: oRow=%h oCol=%h busy=%b fin=%b, want all 0", oRow, oCol, oBusy, oFin);
      end
      $display("reset/idle checked");
   endtask

   task automatic test_stream();
      fill_default(100);
      start_tile();
      for (int s = 0; s < 9; s++) begin
         checks++;
         if (oRow !== exp_vec5(0, s) || oCol !== exp_vec5(100, s) || oBusy !== 1'b1 || oFin !== 1'b0) begin
            errors++;
            $display("FAIL stream_step%0d: oRow=%h oCol=%h busy=%b fin=%b, want oRow=%h oCol=%h busy=1 fin=0",
                     s, oRow, oCol, oBusy, oFin, exp_vec5(0, s), exp_vec5(100, s));
         end
         if (s == 0) begin
            checks++;
            if (oRow !== 40'h0 || oCol !== {8'd0, 8'd0, 8'd0, 8'd0, 8'd100}) begin
               errors++;
               $display("FAIL step0_const: oRow=%h oCol=%h, want 0 and 00..64", oRow, oCol);
            end
         end
         if (s == 4) begin
            checks++;
            if (oRow !== {8'd20, 8'd16, 8'd12, 8'd8, 8'd4} ||
                oCol !== {8'd120, 8'd116, 8'd112, 8'd108, 8'd104}) begin
               errors++;
               $display("FAIL step4_const: oRow=%h oCol=%h", oRow, oCol);
            end
         end
         if (s == 8) begin
            checks++;
            if (oRow !== {8'd24, 8'd0, 8'd0, 8'd0, 8'd0} || oCol !== {8'd124, 8'd0, 8'd0, 8'd0, 8'd0}) begin
               errors++;
               $display("FAIL step8_const: oRow=%h oCol=%h", oRow, oCol);
            end
         end
         tick();
      end
      checks++;
      if (oFin !== 1'b1 || oBusy !== 1'b0 || oRow !== '0 || oCol !== '0) begin
         errors++;
         $display("FAIL done_edge9: fin=%b busy=%b oRow=%h oCol=%h, want fin=1 busy=0 zeros", oFin, oBusy, oRow, oCol);
      end
      tick();
      checks++;
      if (oFin !== 1'b0 || oBusy !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width: fin=%b busy=%b, want 0 0", oFin, oBusy);
      end
      $display("stream tile checked");
   endtask

   task automatic test_stall();
      fill_default(100);
      start_tile();
      tick(); tick();
      iStall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (oRow !== exp_vec5(0, 2) || oCol !== exp_vec5(100, 2) || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: oRow=%h oCol=%h busy=%b, want %h %h 1",
                     c, oRow, oCol, oBusy, exp_vec5(0, 2), exp_vec5(100, 2));
         end
      end
      iStall = 1'b0;
      for (int e = 6; e <= 12; e++) begin
         tick();
         checks++;
         if (oFin !== (e == 12)) begin
            errors++;
            $display("FAIL stall_pulse_edge%0d: fin=%b, want %b", e, oFin, (e == 12));
         end
      end
      tick();
      $display("stall checked");
   endtask

   task automatic test_small();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 3; k++) iRow2[r][k] = 8'(1 + 10 * r + k);
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 3; k++) iCol2[c][k] = 8'(50 + 10 * c + k);
      iStart2 = 1'b1;
      tick();
      iStart2 = 1'b0;
      for (int s = 0; s < 6; s++) begin
         logic [1:0][7:0] er;
         logic [3:0][7:0] ec;
         for (int l = 0; l < 2; l++) er[l] = exp_lane(1, 10, 3, l, s);
         for (int l = 0; l < 4; l++) ec[l] = exp_lane(50, 10, 3, l, s);
         checks++;
         if (oRow2 !== er || oCol2 !== ec || oFin2 !== 1'b0) begin
            errors++;
            $display("FAIL small_step%0d: oRow=%h oCol=%h fin=%b, want %h %h 0", s, oRow2, oCol2, oFin2, er, ec);
         end
         if (s >= 4) begin
            checks++;
            if (oRow2 !== '0) begin
               errors++;
               $display("FAIL small_rowzero%0d: oRow=%h, want 0", s, oRow2);
            end
         end
         if (s >= 3) begin
            checks++;
            if (oCol2[3] !== 8'(80 + s - 3)) begin
               errors++;
               $display("FAIL small_col3_step%0d: got %0d want %0d", s, oCol2[3], 80 + s - 3);
            end
         end
         tick();
      end
      checks++;
      if (oFin2 !== 1'b1 || oBusy2 !== 1'b0) begin
         errors++;
         $display("FAIL small_done: fin=%b busy=%b, want 1 0", oFin2, oBusy2);
      end
      tick();
      $display("2x4x3 tile checked");
   endtask

   task automatic test_back_to_back();
      fill_default(100);
      start_tile();
      tick(); tick();
      iStart = 1'b1;
      iRow = {25{8'hFF}};
      tick();
      iStart = 1'b0;
      checks++;
      if (oRow !== exp_vec5(0, 3) || oCol !== exp_vec5(100, 3) || oBusy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start: oRow=%h oCol=%h busy=%b, want %h %h 1", oRow, oCol, oBusy, exp_vec5(0, 3), exp_vec5(100, 3));
      end
      tick(); tick(); tick(); tick();
      checks++;
      if (oRow !== exp_vec5(0, 7) || oCol !== exp_vec5(100, 7)) begin
         errors++;
         $display("FAIL ignore_start_step7: oRow=%h oCol=%h, want %h %h", oRow, oCol, exp_vec5(0, 7), exp_vec5(100, 7));
      end
      tick();
      fill_default(101);
      iStart = 1'b1;
      tick();
      checks++;
      if (oFin !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: fin=%b, want 1", oFin);
      end
      tick();
      iStart = 1'b0;
      checks++;
      if (oFin !== 1'b0 || oBusy !== 1'b1 || oRow !== exp_vec5(0, 0) || oCol !== exp_vec5(101, 0)) begin
         errors++;
         $display("FAIL b2b_restart: fin=%b busy=%b oRow=%h oCol=%h, want 0 1 %h %h",
                  oFin, oBusy, oRow, oCol, exp_vec5(0, 0), exp_vec5(101, 0));
      end
      for (int e = 1; e <= 9; e++) begin
         tick();
         checks++;
         if (oFin !== (e == 9)) begin
            errors++;
            $display("FAIL b2b_pulse_edge%0d: fin=%b, want %b", e, oFin, (e == 9));
         end
      end
      tick();
      $display("back-to-back checked");
   endtask

   task automatic test_reset_mid();
      bit seen;
      fill_default(100);
      start_tile();
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (oRow !== '0 || oCol !== '0 || oBusy !== 1'b0 || oFin !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: oRow=%h oCol=%h busy=%b fin=%b, want all 0", oRow, oCol, oBusy, oFin);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (oFin !== 1'b0 || oBusy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_no_pulse: activity seen after aborted tile, want none");
      end
      start_tile();
      tick(); tick(); tick(); tick();
      checks++;
      if (oRow !== exp_vec5(0, 4) || oCol !== exp_vec5(100, 4)) begin
         errors++;
         $display("FAIL reset_rerun_step4: oRow=%h oCol=%h, want %h %h", oRow, oCol, exp_vec5(0, 4), exp_vec5(100, 4));
      end
      tick(); tick(); tick(); tick(); tick();
      checks++;
      if (oFin !== 1'b1) begin
         errors++;
         $display("FAIL reset_rerun_done: fin=%b, want 1", oFin);
      end
      tick();
      $display("mid-stream reset checked");
   endtask

`ifdef SKEW_VALID_MASK_EN
   task automatic test_valid_mask();
      fill_default(100);
      checks++;
      if (oRowValid !== 5'b0 || oColValid !== 5'b0) begin
         errors++;
         $display("FAIL mask_idle: row=%b col=%b, want 0 0", oRowValid, oColValid);
      end
      start_tile();
      for (int s = 0; s < 9; s++) begin
         if (s == 0 || s == 4 || s == 6) begin
            logic [4:0] em;
            em = (s == 0) ? 5'b00001 : (s == 4) ? 5'b11111 : 5'b11100;
            checks++;
            if (oRowValid !== em || oColValid !== em) begin
               errors++;
               $display("FAIL mask_step%0d: row=%b col=%b, want %b", s, oRowValid, oColValid, em);
            end
         end
         tick();
      end
      checks++;
      if (oRowValid !== 5'b0 || oColValid !== 5'b0 || oFin !== 1'b1) begin
         errors++;
         $display("FAIL mask_done: row=%b col=%b fin=%b, want 0 0 1", oRowValid, oColValid, oFin);
      end
      tick();
      $display("valid masks checked");
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_small();
      test_back_to_back();
      test_reset_mid();
`ifdef SKEW_VALID_MASK_EN
      test_valid_mask();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
